// File: rtl/alu_serial_seq.sv
// alu_serial_seq -- bit-serial sequencer around an external 1-bit ALU slice.
// It walks the operands LSB first and feeds one bit per clock to a
// combinational slice. It rebuilds the WIDTH-bit result from the slice outputs.
// SLT takes one extra pass: the sign of the difference is fed back into bit 0.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   start, a_in, b_in        request and operands (sampled on accepted start)
//   alu_ctl                  {sa, sb, op[1:0]}
//   slice_a/b/sa/sb/cin/sm/op  drive to the external slice
//   slice_result/set/ovf     slice response
//   busy, done               handshake (done is a one-cycle pulse)
//   result, zero, ovf        final outputs, held until the next run completes
module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       alu_ctl,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_sa,
    output logic             slice_sb,
    output logic             slice_cin,
    output logic             slice_sm,
    output logic [1:0]       slice_op,
    input  logic             slice_result,
    input  logic             slice_set,
    input  logic             slice_ovf,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q, res_sh;
    logic [3:0]       ctl_q;
    logic [IW-1:0]    idx;
    logic             carry, set_q, ovf_q;
    logic             accept;

    // The done pulse cycle also blocks a new start, so a request is never
    // taken while the previous result is being presented.
    assign accept = (state == IDLE) && start && !done;

    // Slice drive is purely combinational from the latched operands.
    assign slice_a   = a_q[idx];
    assign slice_b   = b_q[idx];
    assign slice_sa  = ctl_q[3];
    assign slice_sb  = ctl_q[2];
    assign slice_op  = ctl_q[1:0];
    assign slice_cin = carry;
    assign slice_sm  = (state == FIX) ? set_q : 1'b0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = RUN;
            RUN:  if (idx == LAST) state_nx = (ctl_q[1:0] == 2'b11) ? FIX : DONE;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            ctl_q  <= '0;
            res_sh <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            set_q  <= 1'b0;
            ovf_q  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            zero   <= 1'b1;
            ovf    <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= a_in;
                        b_q   <= b_in;
                        ctl_q <= alu_ctl;
                        // Inverted B plus carry-in of one gives two's complement subtract.
                        carry <= alu_ctl[2];
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    res_sh[idx] <= slice_result;
                    // Slice only exposes cin^cout, so recover cout from it.
                    carry <= slice_cin ^ slice_ovf;
                    if (idx == LAST) begin
                        set_q <= slice_set;
                        ovf_q <= slice_ovf;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FIX: begin
                    // Upper bits were already written as 0 (sm=0 during RUN).
                    res_sh[0] <= slice_result;
                end
                DONE: begin
                    result <= res_sh;
                    zero   <= (res_sh == '0);
                    ovf    <= (ctl_q[1:0] == 2'b10) ? ovf_q : 1'b0;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
module tb_alu_serial_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a_in, b_in;
    logic [3:0]    alu_ctl;
    logic          slice_a, slice_b, slice_sa, slice_sb, slice_cin, slice_sm;
    logic [1:0]    slice_op;
    logic          slice_result, slice_set, slice_ovf;
    logic          busy, done, zero, ovf;
    logic [W-1:0]  result;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .alu_ctl(alu_ctl),
        .slice_a(slice_a), .slice_b(slice_b), .slice_sa(slice_sa),
        .slice_sb(slice_sb), .slice_cin(slice_cin), .slice_sm(slice_sm),
        .slice_op(slice_op), .slice_result(slice_result),
        .slice_set(slice_set), .slice_ovf(slice_ovf),
        .busy(busy), .done(done), .result(result), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Ideal 1-bit ALU slice.
    logic aa, bb, sum, cout;
    always_comb begin
        aa        = slice_a ^ slice_sa;
        bb        = slice_b ^ slice_sb;
        sum       = aa ^ bb ^ slice_cin;
        cout      = (aa & bb) | (aa & slice_cin) | (bb & slice_cin);
        slice_ovf = slice_cin ^ cout;
        slice_set = sum ^ slice_ovf;
        case (slice_op)
            2'b00:   slice_result = aa & bb;
            2'b01:   slice_result = aa | bb;
            2'b10:   slice_result = sum;
            default: slice_result = slice_sm;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         o;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           n_chk = 0;
    int           n_fail = 0;
    logic [W-1:0] prev_res = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("zero", W'(zero), W'(e.z));
                chk("ovf", W'(ovf), W'(e.o));
                chk("done_cycle", W'(cyc), W'(e.cyc));
                chk("busy_at_done", W'(busy), '0);
            end
        end
    end

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
            sb.delete();
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c,
                         input logic [W-1:0] er, input logic eo, input int lat);
        exp_t e;
        @(negedge clk);
        a_in = a; b_in = b; alu_ctl = c; start = 1'b1;
        e.res = er; e.z = (er == '0); e.o = eo; e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", W'(busy), W'(1));
        chk("result_hold", result, prev_res);
        wait_drain(100);
        prev_res = er;
    endtask

    initial begin
        int s0;
        exp_t e;
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; alu_ctl = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_result", result, '0);
        chk("rst_zero", W'(zero), W'(1));
        chk("rst_ovf", W'(ovf), '0);
        chk("rst_slice", W'({slice_a, slice_b, slice_sa, slice_sb, slice_cin, slice_sm, slice_op}), '0);
        rst = 1'b0;

        // ADD / SUB
        do_op(32'd7,         32'd5,         4'b0010, 32'h0000000C, 1'b0, 33);
        do_op(32'h80000000,  32'd1,         4'b0110, 32'h7FFFFFFF, 1'b1, 33);
        do_op(32'd5,         32'd5,         4'b0110, 32'h00000000, 1'b0, 33);
        do_op(32'h7FFFFFFF,  32'd1,         4'b0010, 32'h80000000, 1'b1, 33);
        // SLT (ovf forced 0)
        do_op(32'hFFFFFFFF,  32'd1,         4'b0111, 32'h00000001, 1'b0, 34);
        do_op(32'h7FFFFFFF,  32'h80000000,  4'b0111, 32'h00000000, 1'b0, 34);
        do_op(32'd3,         32'd9,         4'b0111, 32'h00000001, 1'b0, 34);
        // Logic ops
        do_op(32'h0,         32'h0,         4'b1100, 32'hFFFFFFFF, 1'b0, 33);
        do_op(32'hF0F0F0F0,  32'hFF00FF00,  4'b0000, 32'hF000F000, 1'b0, 33);
        do_op(32'hF0F0F0F0,  32'hFF00FF00,  4'b0001, 32'hFFF0FFF0, 1'b0, 33);

        // start pulses during a run (incl. the DONE-state cycle) are ignored
        @(negedge clk);
        a_in = 32'h10; b_in = 32'h20; alu_ctl = 4'b0010; start = 1'b1;
        s0 = cyc + 1;
        e.res = 32'h30; e.z = 1'b0; e.o = 1'b0; e.cyc = s0 + 33;
        sb.push_back(e);
        while (cyc < s0 + 34) begin
            @(negedge clk);
            if (cyc == s0 + 5 || cyc == s0 + 20 || cyc == s0 + 32) begin
                a_in = 32'hDEAD0000; b_in = 32'h1111; alu_ctl = 4'b0001; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        wait_drain(100);
        repeat (40) @(negedge clk);
        chk("idle_after_ignored", W'(busy), '0);
        prev_res = 32'h30;

        // reset in the middle of an ADD
        @(negedge clk);
        a_in = 32'd1; b_in = 32'd2; alu_ctl = 4'b0010; start = 1'b1;
        s0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < s0 + 10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", W'(busy), '0);
        chk("abort_result", result, '0);
        chk("abort_zero", W'(zero), W'(1));
        chk("abort_done", W'(done), '0);
        @(negedge clk);
        rst = 1'b0;
        prev_res = '0;
        repeat (40) @(negedge clk);
        do_op(32'd3, 32'd4, 4'b0010, 32'd7, 1'b0, 33);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test expected end before time limit");
        $fatal(1, "watchdog");
    end

endmodule
